// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: address/instruction widths, reset PC and the
// {pc, instruction} entry passed from fetch to decode.
package cpu_pkg;

  localparam int ADDR_WIDTH        = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]        pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush wins over push and pop.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  fetch_entry_t  store [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Qualify requests against occupancy; pop frees the slot a full push needs.
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
  end

  // Pointer and occupancy control; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage carries no reset; only valid entries are ever presented.
  always_ff @(posedge clk) begin
    if (do_push && !flush) store[wr_ptr] <= push_entry;
  end

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = store[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads under a credit limit,
// tags returning words with their PC and buffers them for the decoder.
// Redirects flush the buffer and turn every in-flight read into a drop.
module fetch_unit #(
  parameter logic [cpu_pkg::ADDR_WIDTH-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  output logic                                  imem_req_valid,
  input  logic                                  imem_req_ready,
  output logic [cpu_pkg::ADDR_WIDTH-1:0]        imem_req_addr,
  input  logic                                  imem_rsp_valid,
  input  logic [cpu_pkg::INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                                  redirect_valid,
  input  logic [cpu_pkg::ADDR_WIDTH-1:0]        redirect_pc,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [cpu_pkg::INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [cpu_pkg::ADDR_WIDTH-1:0]        out_pc
);

  import cpu_pkg::*;

  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 2;

  logic [AW-1:0] pc;
  logic [AW-1:0] rsp_pc;
  logic [CW-1:0] live;
  logic [CW-1:0] stale;
  logic          run;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;

  logic [SW-1:0] credit_sum;
  logic          credit_ok;
  logic          req_fire;
  logic          rsp_is_stale;
  logic          rsp_push;
  logic [AW-1:0] redir_pc;

  // Credit, handshake and response classification.
  always_comb begin
    credit_sum     = SW'(fifo_count) + SW'(live) + SW'(stale);
    credit_ok      = credit_sum < SW'(FIFO_DEPTH);
    imem_req_valid = run && !redirect_valid && credit_ok;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_is_stale   = (stale != '0);
    rsp_push       = imem_rsp_valid && !rsp_is_stale && !redirect_valid;
    redir_pc       = {redirect_pc[AW-1:2], 2'b00};
    fifo_pop       = out_ready && !fifo_empty;
    push_entry     = '{pc: rsp_pc, instruction: imem_rsp_data};
  end

  // Requests start the cycle after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // PC, response PC and in-flight counters; a redirect overrides all other updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      rsp_pc <= RESET_PC;
      live   <= '0;
      stale  <= '0;
    end else if (redirect_valid) begin
      pc     <= redir_pc;
      rsp_pc <= redir_pc;
      stale  <= stale + live - CW'(imem_rsp_valid);
      live   <= '0;
    end else begin
      if (req_fire) pc <= pc + AW'(4);
      if (imem_rsp_valid && !rsp_is_stale) rsp_pc <= rsp_pc + AW'(4);
      stale <= stale - CW'(imem_rsp_valid && rsp_is_stale);
      live  <= live + CW'(req_fire) - CW'(imem_rsp_valid && !rsp_is_stale);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (rsp_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .head       (fifo_head)
  );

  assign imem_req_addr   = pc;
  assign out_valid       = !fifo_empty;
  assign out_instruction = fifo_head.instruction;
  assign out_pc          = fifo_head.pc;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_push && fifo_full && !fifo_pop));
  a_live_bound: assert property (@(posedge clk) disable iff (!rst)
    live <= CW'(FIFO_DEPTH));
  a_stale_bound: assert property (@(posedge clk) disable iff (!rst)
    stale <= CW'(FIFO_DEPTH));
  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (live != '0 || stale != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency, random
// handshakes and redirects, checked against a stream-level model of fetch.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] MASK = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mq[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          buffered = 0;
  int          epoch = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          delivered = 0;
  int          since_rel = -1;
  int          first_valid_cyc = -1;
  bit          started = 1'b0;
  bit          got_first = 1'b0;
  bit          seen40 = 1'b0;
  logic [31:0] first_after = 'x;
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] exp_out = RESET_PC;

  int          p_rdy = 100;
  int          p_ordy = 100;
  int          p_redir = 0;
  int          d_min = 1;
  int          d_max = 1;
  bit          hold_rst = 1'b1;
  bit          force_redir = 1'b0;
  logic [31:0] force_pc = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit pick(input int p);
    return $urandom_range(99) < p;
  endfunction

  // One clock cycle: drive inputs after the edge, check and advance the model at negedge.
  task automatic step();
    bit   exp_rv;
    int   bpre;
    req_t e;
    @(posedge clk);
    #1;
    cyc++;
    rst = !hold_rst;
    if (!rst) begin
      mq.delete();
      buffered = 0;
      epoch++;
      exp_req = RESET_PC;
      exp_out = RESET_PC;
      n_acc = 0;
      since_rel = -1;
      first_valid_cyc = -1;
      got_first = 1'b0;
      first_after = 'x;
      force_redir = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b0;
    end else begin
      since_rel++;
      imem_req_ready = pick(p_rdy);
      out_ready = pick(p_ordy);
      redirect_valid = force_redir || pick(p_redir);
      redirect_pc = force_redir ? force_pc : $urandom;
      force_redir = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mem_word(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = $urandom;
      end
    end
    @(negedge clk);
    if (!rst) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
    end else begin
      exp_rv = started && !redirect_valid && (mq.size() + buffered < DEPTH);
      check("req_valid", imem_req_valid, exp_rv);
      check("req_addr", imem_req_addr, exp_req);
      check("out_valid", out_valid, buffered > 0);
      if (buffered > 0) begin
        check("out_pc", out_pc, exp_out);
        check("out_instruction", out_instruction, mem_word(exp_out));
      end
      if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = since_rel;
      bpre = buffered;
      if (imem_rsp_valid) begin
        e = mq.pop_front();
        if (!redirect_valid && e.epoch == epoch) buffered++;
      end
      if (bpre > 0 && out_ready && !redirect_valid) begin
        buffered--;
        delivered++;
        if (!got_first) begin
          first_after = out_pc;
          got_first = 1'b1;
        end
        if (out_pc == 32'h40) seen40 = 1'b1;
        exp_out += 4;
      end
      if (exp_rv && imem_req_ready) begin
        e.addr = exp_req;
        e.epoch = epoch;
        e.due = cyc + int'($urandom_range(d_max, d_min));
        mq.push_back(e);
        exp_req += 4;
        n_acc++;
      end
      if (redirect_valid) begin
        epoch++;
        buffered = 0;
        exp_req = redirect_pc & MASK;
        exp_out = redirect_pc & MASK;
        got_first = 1'b0;
        first_after = 'x;
      end
    end
    started = rst;
  endtask

  task automatic do_reset();
    hold_rst = 1'b1;
    step();
    step();
    hold_rst = 1'b0;
  endtask

  task automatic set_knobs(input int rdy, input int ordy, input int redir, input int dmin, input int dmax);
    p_rdy = rdy;
    p_ordy = ordy;
    p_redir = redir;
    d_min = dmin;
    d_max = dmax;
  endtask

  initial begin
    bit hit;

    // Reset release with single-cycle memory and a free-running decoder.
    set_knobs(100, 100, 0, 1, 1);
    do_reset();
    repeat (14) step();
    check("a_first_valid_cycle", first_valid_cyc, 3);
    check("a_first_out_pc", first_after, 32'h0);

    // Decoder stalls: buffer fills to depth, requests stop, stream resumes in order.
    p_ordy = 0;
    repeat (10) step();
    check("b_out_valid_held", out_valid, 1);
    check("b_req_valid_off", imem_req_valid, 0);
    p_ordy = 100;
    repeat (10) step();

    // Memory stalls after two accepts: the third address is held.
    do_reset();
    for (int i = 0; i < 20 && n_acc < 2; i++) step();
    check("c_two_accepts", n_acc, 2);
    p_rdy = 0;
    repeat (5) step();
    check("c_addr_held", imem_req_addr, 32'h8);
    check("c_req_pending", imem_req_valid, 1);
    p_rdy = 100;
    repeat (8) step();

    // Redirect with two reads in flight: both are dropped.
    do_reset();
    set_knobs(100, 100, 0, 3, 3);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 2) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    if (!hit) check("d_wait_inflight", mq.size(), 2);
    force_redir = 1'b1;
    force_pc = 32'h103;
    step();
    d_min = 1;
    d_max = 1;
    step();
    check("d_addr_after_redirect", imem_req_addr, 32'h100);
    check("d_credit_blocked", imem_req_valid, 0);
    repeat (15) step();
    check("d_first_pc", first_after, 32'h100);

    // Redirect coinciding with a response and an output handshake.
    do_reset();
    set_knobs(100, 100, 0, 1, 1);
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (buffered > 0 && mq.size() > 0 && mq[0].due <= cyc + 1) begin
        force_redir = 1'b1;
        force_pc = 32'h200;
        hit = 1'b1;
      end
      step();
    end
    if (!hit) check("e_wait_collision", hit, 1);
    step();
    check("e_fifo_flushed", out_valid, 0);
    check("e_no_stale_left", imem_req_valid, 1);
    check("e_new_addr", imem_req_addr, 32'h200);
    repeat (10) step();
    check("e_first_pc", first_after, 32'h200);

    // Back-to-back redirects: only the second target is fetched.
    do_reset();
    set_knobs(70, 100, 0, 1, 3);
    repeat (6) step();
    seen40 = 1'b0;
    force_redir = 1'b1;
    force_pc = 32'h40;
    step();
    force_redir = 1'b1;
    force_pc = 32'h80;
    step();
    repeat (20) step();
    check("f_first_pc", first_after, 32'h80);
    check("f_no_0x40", seen40, 0);

    // Random traffic, a PC wrap and a reset in the middle of activity.
    do_reset();
    set_knobs(100, 100, 0, 1, 1);
    step();
    force_redir = 1'b1;
    force_pc = 32'hFFFF_FFF9;
    step();
    delivered = 0;
    for (int blk = 0; blk < 12; blk++) begin
      set_knobs($urandom_range(100, 30), $urandom_range(100, 30), 3, 1, $urandom_range(4, 1));
      repeat (200) step();
      if (blk == 6) begin
        hold_rst = 1'b1;
        step();
        step();
        hold_rst = 1'b0;
      end
    end
    check("g_progress", delivered > 200, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
